// File: rtl/display_pkg.sv
// Shared display definitions: mode encoding and the auto-rotate successor.
// The display formatter imports this package as well.
package display_pkg;

  // Display modes; encoding 2'd3 is never produced.
  typedef enum logic [1:0] {
    MODE_TIME = 2'd0,
    MODE_DATE = 2'd1,
    MODE_TMR  = 2'd2
  } mode_t;

  // Successor mode for auto-rotation. When the timer is excluded, DATE wraps
  // straight back to TIME. A manually entered TMR mode also returns to TIME.
  function automatic mode_t next_mode(input mode_t cur, input logic tmr_en);
    mode_t nxt;
    case (cur)
      MODE_TIME: nxt = MODE_DATE;
      MODE_DATE: nxt = tmr_en ? MODE_TMR : MODE_TIME;
      MODE_TMR:  nxt = MODE_TIME;
      default:   nxt = MODE_TIME;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for auto-rotation. Counts enabled cycles and raises a
// combinational tick on the cycle where the count reaches DWELL-1; the
// count wraps to zero on that same edge. clr has priority over en.
module dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  logic [CW-1:0] cnt_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign tick      = en && at_last_s;

  // Count register: clear on reset or clr, wrap at DWELL-1, hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (clr) begin
      cnt_r <= ZERO;
    end else if (en) begin
      if (at_last_s) begin
        cnt_r <= ZERO;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/display_field_sel.sv
// Registered display field selector. Picks the time, date or timer field
// triplet from a latched one-hot request or an auto-rotating mode, with a
// freeze control on the output buses and a delayed change strobe.
module display_field_sel
  import display_pkg::*;
#(
  parameter int N      = 8,
  parameter int DWELL  = 50_000_000,
  parameter bit TMR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   sel,
  input  logic         auto_en,
  input  logic         freeze,
  input  logic [N-1:0] t_hora,
  input  logic [N-1:0] t_min,
  input  logic [N-1:0] t_seg,
  input  logic [N-1:0] d_dia,
  input  logic [N-1:0] d_mes,
  input  logic [N-1:0] d_year,
  input  logic [N-1:0] c_hora,
  input  logic [N-1:0] c_min,
  input  logic [N-1:0] c_seg,
  output logic [N-1:0] dato_1,
  output logic [N-1:0] dato_2,
  output logic [N-1:0] dato_3,
  output logic [1:0]   mode_act,
  output logic         upd
);

  mode_t        mode_r;
  mode_t        mode_nxt_s;
  mode_t        enc_s;
  logic         sel_any_s;
  logic         tick_s;
  logic [N-1:0] mux_1_s;
  logic [N-1:0] mux_2_s;
  logic [N-1:0] mux_3_s;
  logic         chg_s;
  logic         chg_r;

  assign sel_any_s = |sel;
  assign mode_act  = mode_r;

  // A manual request clears the dwell count; counting only runs when idle
  // and auto-rotation is enabled.
  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .en   (auto_en && !sel_any_s),
    .clr  (sel_any_s),
    .tick (tick_s)
  );

  // Next mode: priority-encoded request beats dwell expiry, else hold.
  always_comb begin
    enc_s      = MODE_TIME;
    mode_nxt_s = mode_r;
    if (sel[0]) begin
      enc_s = MODE_TIME;
    end else if (sel[1]) begin
      enc_s = MODE_DATE;
    end else if (sel[2]) begin
      enc_s = MODE_TMR;
    end else begin
      enc_s = MODE_TIME;
    end
    if (sel_any_s) begin
      mode_nxt_s = enc_s;
    end else if (tick_s) begin
      mode_nxt_s = next_mode(mode_r, TMR_EN);
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Field mux driven from the next-state mode so data and mode_act align.
  always_comb begin
    mux_1_s = t_hora;
    mux_2_s = t_min;
    mux_3_s = t_seg;
    case (mode_nxt_s)
      MODE_TIME: begin
        mux_1_s = t_hora;
        mux_2_s = t_min;
        mux_3_s = t_seg;
      end
      MODE_DATE: begin
        mux_1_s = d_dia;
        mux_2_s = d_mes;
        mux_3_s = d_year;
      end
      MODE_TMR: begin
        mux_1_s = c_hora;
        mux_2_s = c_min;
        mux_3_s = c_seg;
      end
      default: begin
        mux_1_s = t_hora;
        mux_2_s = t_min;
        mux_3_s = t_seg;
      end
    endcase
  end

  // A load that alters any bus is flagged here and surfaces on upd one
  // cycle later.
  assign chg_s = !freeze &&
                 ((mux_1_s != dato_1) || (mux_2_s != dato_2) || (mux_3_s != dato_3));

  // Mode register keeps running while the outputs are frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= MODE_TIME;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Output buses load live values unless frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_1 <= {N{1'b0}};
      dato_2 <= {N{1'b0}};
      dato_3 <= {N{1'b0}};
    end else if (!freeze) begin
      dato_1 <= mux_1_s;
      dato_2 <= mux_2_s;
      dato_3 <= mux_3_s;
    end else begin
      dato_1 <= dato_1;
      dato_2 <= dato_2;
      dato_3 <= dato_3;
    end
  end

  // Two-stage change strobe: record the differing load, then pulse upd.
  always_ff @(posedge clk) begin
    if (reset) begin
      chg_r <= 1'b0;
      upd   <= 1'b0;
    end else begin
      chg_r <= chg_s;
      upd   <= chg_r;
    end
  end

endmodule

// File: tb/tb_display_field_sel.sv
// Directed bench for display_field_sel. Two instances share all inputs:
// dut_a has the timer in rotation, dut_b skips it.
module tb_display_field_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sel;
  logic       auto_en;
  logic       freeze;
  logic [7:0] t_hora, t_min, t_seg;
  logic [7:0] d_dia, d_mes, d_year;
  logic [7:0] c_hora, c_min, c_seg;
  logic [7:0] a_d1, a_d2, a_d3, b_d1, b_d2, b_d3;
  logic [1:0] a_mode, b_mode;
  logic       a_upd, b_upd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_field_sel #(.N(8), .DWELL(4), .TMR_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .sel(sel), .auto_en(auto_en), .freeze(freeze),
    .t_hora(t_hora), .t_min(t_min), .t_seg(t_seg),
    .d_dia(d_dia), .d_mes(d_mes), .d_year(d_year),
    .c_hora(c_hora), .c_min(c_min), .c_seg(c_seg),
    .dato_1(a_d1), .dato_2(a_d2), .dato_3(a_d3),
    .mode_act(a_mode), .upd(a_upd)
  );

  display_field_sel #(.N(8), .DWELL(4), .TMR_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .sel(sel), .auto_en(auto_en), .freeze(freeze),
    .t_hora(t_hora), .t_min(t_min), .t_seg(t_seg),
    .d_dia(d_dia), .d_mes(d_mes), .d_year(d_year),
    .c_hora(c_hora), .c_min(c_min), .c_seg(c_seg),
    .dato_1(b_d1), .dato_2(b_d2), .dato_3(b_d3),
    .mode_act(b_mode), .upd(b_upd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dato(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3);
    chk({tag, "_d1"}, {24'd0, a_d1}, {24'd0, e1});
    chk({tag, "_d2"}, {24'd0, a_d2}, {24'd0, e2});
    chk({tag, "_d3"}, {24'd0, a_d3}, {24'd0, e3});
  endtask

  initial begin
    // Reset overrides a pending request and freeze.
    reset = 1'b1; sel = 3'b010; freeze = 1'b1; auto_en = 1'b0;
    t_hora = 8'd12; t_min = 8'd34; t_seg = 8'd56;
    d_dia  = 8'd7;  d_mes = 8'd6;  d_year = 8'd16;
    c_hora = 8'd1;  c_min = 8'd2;  c_seg = 8'd3;
    step();
    chk_dato("rst", 8'd0, 8'd0, 8'd0);
    chk("rst_mode", {30'd0, a_mode}, 32'd0);
    chk("rst_upd", {31'd0, a_upd}, 32'd0);
    chk("rst_mode_b", {30'd0, b_mode}, 32'd0);

    // Manual priority: sel[0] beats sel[1].
    reset = 1'b0; freeze = 1'b0; sel = 3'b011;
    step();
    chk("pri_mode", {30'd0, a_mode}, 32'd0);
    chk_dato("pri", 8'd12, 8'd34, 8'd56);
    chk("pri_upd", {31'd0, a_upd}, 32'd0);
    sel = 3'b010;
    step();
    chk("date_mode", {30'd0, a_mode}, 32'd1);
    chk_dato("date", 8'd7, 8'd6, 8'd16);
    sel = 3'b000;
    step();
    chk("date_upd", {31'd0, a_upd}, 32'd1);
    chk("date_hold_mode", {30'd0, a_mode}, 32'd1);
    step();
    chk("date_upd_end", {31'd0, a_upd}, 32'd0);

    // Live tracking in date mode.
    d_year = 8'd17;
    step();
    chk("live_d3", {24'd0, a_d3}, 32'd17);
    chk("live_upd0", {31'd0, a_upd}, 32'd0);
    step();
    chk("live_upd1", {31'd0, a_upd}, 32'd1);
    step();
    chk("live_upd2", {31'd0, a_upd}, 32'd0);
    step();
    chk("quiet_upd", {31'd0, a_upd}, 32'd0);

    // Freeze holds outputs; release loads the live value.
    sel = 3'b001;
    step();
    sel = 3'b000;
    chk_dato("time", 8'd12, 8'd34, 8'd56);
    step();
    step();
    freeze = 1'b1; t_seg = 8'd57;
    step();
    chk("frz_d3", {24'd0, a_d3}, 32'd56);
    chk("frz_upd", {31'd0, a_upd}, 32'd0);
    step();
    chk("frz_d3_b", {24'd0, a_d3}, 32'd56);
    chk("frz_upd_b", {31'd0, a_upd}, 32'd0);
    freeze = 1'b0;
    step();
    chk("rel_d3", {24'd0, a_d3}, 32'd57);
    chk("rel_upd0", {31'd0, a_upd}, 32'd0);
    step();
    chk("rel_upd1", {31'd0, a_upd}, 32'd1);

    // Freeze together with a mode change: mode moves, data holds.
    freeze = 1'b1; sel = 3'b010;
    step();
    chk("frzmode_mode", {30'd0, a_mode}, 32'd1);
    chk("frzmode_d1", {24'd0, a_d1}, 32'd12);
    freeze = 1'b0; sel = 3'b000;
    step();
    chk_dato("frzmode_rel", 8'd7, 8'd6, 8'd17);

    // Auto-rotation from mode 0 with a cleared counter.
    sel = 3'b001;
    step();
    sel = 3'b000; auto_en = 1'b1;
    step(); step(); step();
    chk("auto3_a", {30'd0, a_mode}, 32'd0);
    step();
    chk("auto4_a", {30'd0, a_mode}, 32'd1);
    chk("auto4_b", {30'd0, b_mode}, 32'd1);
    chk("auto4_d1", {24'd0, a_d1}, 32'd7);
    step(); step(); step(); step();
    chk("auto8_a", {30'd0, a_mode}, 32'd2);
    chk("auto8_b", {30'd0, b_mode}, 32'd0);
    chk("auto8_d1", {24'd0, a_d1}, 32'd1);
    step(); step(); step(); step();
    chk("auto12_a", {30'd0, a_mode}, 32'd0);
    chk("auto12_b", {30'd0, b_mode}, 32'd1);

    // Collision: request on the expiry cycle wins and restarts the dwell.
    step(); step(); step();
    sel = 3'b100;
    step();
    chk("coll_a", {30'd0, a_mode}, 32'd2);
    chk("coll_b", {30'd0, b_mode}, 32'd2);
    sel = 3'b000;
    step(); step(); step();
    chk("coll3_a", {30'd0, a_mode}, 32'd2);
    step();
    chk("coll4_a", {30'd0, a_mode}, 32'd0);
    chk("coll4_b", {30'd0, b_mode}, 32'd0);

    // Disabling auto holds mode and count; resume counts from held value.
    step(); step();
    auto_en = 1'b0;
    step(); step(); step();
    chk("hold_a", {30'd0, a_mode}, 32'd0);
    auto_en = 1'b1;
    step();
    chk("resume1_a", {30'd0, a_mode}, 32'd0);
    step();
    chk("resume2_a", {30'd0, a_mode}, 32'd1);

    // Reset mid-dwell discards the count.
    step(); step();
    reset = 1'b1;
    step();
    chk("rst2_mode", {30'd0, a_mode}, 32'd0);
    reset = 1'b0;
    step(); step(); step();
    chk("rst2_3", {30'd0, a_mode}, 32'd0);
    step();
    chk("rst2_4", {30'd0, a_mode}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_field_sel.md
# display_field_sel

Registered, parametrised successor to the combinational time/date/timer output selector. It picks one of three N-bit field triplets (time, date, timer) and drives them onto the three display data buses. A selection is either latched from one-hot requests or rotated automatically on a dwell counter. The block sits between the RTC register file / timer block and the display formatter, and adds a freeze control and an update strobe for downstream redraw.

## Interface
- `N`, 8: width of each field and each output bus.
- `DWELL`, 50_000_000: clock cycles each mode is shown in auto-rotate (≥1).
- `TMR_EN`, 1: 1 = timer mode reachable in auto-rotate; 0 = rotation skips it.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `sel` in 3: one-hot request; [0] time, [1] date, [2] timer.
- `auto_en` in 1: enable auto-rotation.
- `freeze` in 1: hold output buses.
- `t_hora`, `t_min`, `t_seg` in N each: time fields.
- `d_dia`, `d_mes`, `d_year` in N each: date fields.
- `c_hora`, `c_min`, `c_seg` in N each: timer fields.
- `dato_1`, `dato_2`, `dato_3` out N each: registered display fields.
- `mode_act` out 2: current mode; 0 time, 1 date, 2 timer.
- `upd` out 1: one-cycle pulse when any `dato_*` changes.

## Operation
- The mode register holds 0, 1 or 2; encoding 3 is never produced.
- Manual selection is priority-encoded: `sel[0]` > `sel[1]` > `sel[2]`.
- When `sel` is nonzero, mode loads the encoded value and the dwell counter clears. This applies regardless of `auto_en`.
- When `sel` is zero and `auto_en` is 0, mode and dwell counter hold.
- When `sel` is zero and `auto_en` is 1, the dwell counter increments.
  - When the counter equals DWELL-1, it clears and mode advances 0→1→2→0.
  - With `TMR_EN`=0 the advance is 0→1→0. If mode is 2 (entered manually), the next advance goes to 0.
- Output mux uses the next-state mode:
  - mode 0 → (`t_hora`, `t_min`, `t_seg`)
  - mode 1 → (`d_dia`, `d_mes`, `d_year`)
  - mode 2 → (`c_hora`, `c_min`, `c_seg`)
- When `freeze` is 0, `dato_*` load the muxed values every cycle, so field updates track live.
- When `freeze` is 1, `dato_*` hold. Mode and dwell counter keep operating. On release, outputs load the current selection on the next edge.
- `upd` is registered. It is 1 in the cycle after a `dato_*` load whose value differs from the previous `dato_*` contents.
- `mode_act` is the registered mode.
- Counter width is $clog2(DWELL), minimum 1. With DWELL=1, auto mode advances every cycle.

## Timing
- Reset values: `dato_1`/`dato_2`/`dato_3` = 0, `mode_act` = 0, dwell counter = 0, `upd` = 0.
- Reset overrides `sel`, `freeze` and `auto_en` in the same cycle.
- Reset mid-dwell discards the count.
- Latency is 1 cycle from `sel` or field input to `dato_*` and `mode_act`.
- `upd` asserts 2 cycles after the input change.
- Simultaneous dwell expiry and nonzero `sel`: `sel` wins and the counter clears.
- `freeze` asserted in the same cycle as a mode change: `mode_act` updates, `dato_*` hold.
- In auto mode, the first advance after `auto_en` rises occurs DWELL cycles later, counting from the current counter value (held while disabled).

## Structure
- Shared package `display_pkg` holds:
  - mode constants `MODE_TIME`=2'd0, `MODE_DATE`=2'd1, `MODE_TMR`=2'd2
  - the mode typedef
- These are reused by the display formatter.
- Sub-module `dwell_timer` (params `DWELL`; ports `clk`, `reset`, `en`, `clr`, `tick`) isolates the counter.
- Mode register, mux, output registers and change detect stay in the top.

## Test plan
All scenarios use N=8, DWELL=4, TMR_EN=1.

- Reset: `reset`=1 with `sel`=3'b010 and `freeze`=1 → next cycle all `dato`=0, `mode_act`=0, `upd`=0.
- Manual priority: `t_*`=12/34/56, `d_*`=07/06/16, `sel`=3'b011 for 1 cycle → `mode_act`=0, `dato`=12/34/56. Then `sel`=3'b010 → `mode_act`=1, `dato`=07/06/16, `upd`=1 one cycle later.
- Auto-rotate: `auto_en`=1, `sel`=0 from mode 0 → `mode_act` goes 1, 2, 0 at cycles 4, 8, 12. Rerun with TMR_EN=0 → sequence 1, 0, 1.
- Collision: `sel`=3'b100 exactly on the dwell-expiry cycle → `mode_act`=2, and the next advance comes 4 cycles later.
- Freeze: mode 0, `freeze`=1, `t_seg` 56→57 → `dato_3` stays 56, `upd`=0. Release → `dato_3`=57 next cycle, `upd`=1 the following cycle.
- Live tracking: mode 1, `d_year` 16→17 with `freeze`=0 → `dato_3`=17 after 1 cycle, one `upd` pulse. Unchanged inputs → `upd` stays 0.
